datamem_arbiter: RTL

Two-requester arbiter and sequencer in front of `datamem`, sharing its single access port between the pipeline MEM stage (port 0) and a loader/debug DMA (port 1). It latches one request at a time and screens it for alignment, size and bounds. Legal requests are issued to `datamem` for exactly one cycle; illegal ones never reach it and return an error response. Each requester receives a one-cycle response pulse with registered read data. Arbitration is round-robin.

---
 rtl/datamem_arb_pkg.sv | 13 +
 rtl/access_checker.sv | 19 +
 rtl/datamem_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/datamem_arb_pkg.sv
// datamem_arb_pkg: shared types and defaults for the datamem arbiter slice.
package datamem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic        id;
        logic        legal;
    } cmd_t;
    localparam int DEFAULT_MEM_SIZE = 1024;
endpackage

// File: rtl/access_checker.sv
// access_checker: flags a request legal when its size, alignment and bounds are acceptable.
module access_checker #(
    parameter int MEM_SIZE = 1024
) (
    input  logic [63:0] addr,
    input  logic [3:0]  size,
    output logic        legal
);
    logic        size_ok, aligned, in_bounds;
    logic [64:0] end_addr;
    always_comb begin
        size_ok   = size inside {4'd1, 4'd2, 4'd4, 4'd8};
        aligned   = (addr[3:0] & (size - 4'd1)) == 4'd0;
        // 65-bit sum so a wrapping address cannot sneak under the limit
        end_addr  = {1'b0, addr} + {61'd0, size};
        in_bounds = end_addr <= 65'(MEM_SIZE);
        legal     = size_ok && aligned && in_bounds;
    end
endmodule

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: round-robin two-port sequencer sharing one datamem access port.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int MEM_SIZE = DEFAULT_MEM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [63:0] p0_addr,
    input  logic [63:0] p1_addr,
    input  logic [63:0] p0_wdata,
    input  logic [63:0] p1_wdata,
    input  logic [3:0]  p0_size,
    input  logic [3:0]  p1_size,
    output logic        p0_resp_valid,
    output logic        p1_resp_valid,
    output logic [63:0] p0_rdata,
    output logic [63:0] p1_rdata,
    output logic        p0_err,
    output logic        p1_err,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);
    arb_state_t  state, state_nx;
    cmd_t        cmd;
    logic        rr, sel, grant, legal, s_we, issuing;
    logic [63:0] s_addr, s_wdata, rd_cap;
    logic [3:0]  s_size;

    access_checker #(.MEM_SIZE(MEM_SIZE)) u_chk (.addr(s_addr), .size(s_size), .legal(legal));

    // In RESP only the port not being answered may be granted
    always_comb begin
        sel      = (state == RESP) ? ~cmd.id : (p0_req & p1_req) ? rr : p1_req;
        grant    = (state != ISSUE) && (sel ? p1_req : p0_req);
        state_nx = (state == ISSUE) ? RESP : grant ? ISSUE : IDLE;
        s_we     = sel ? p1_we : p0_we;
        s_addr   = sel ? p1_addr : p0_addr;
        s_wdata  = sel ? p1_wdata : p0_wdata;
        s_size   = sel ? p1_size : p0_size;
        issuing  = state == ISSUE;
        rd_cap   = (cmd.legal && !cmd.we) ? mem_read_data : 64'd0;
    end

    assign mem_address      = cmd.addr;
    assign mem_write_data   = cmd.wdata;
    assign mem_xfer_size    = cmd.size;
    assign mem_write_enable = issuing && cmd.legal && cmd.we && !reset;
    assign mem_read_enable  = issuing && cmd.legal && !cmd.we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr            <= 1'b0;
            cmd           <= '{we: 1'b0, addr: 64'd0, wdata: 64'd0, size: 4'd8, id: 1'b0, legal: 1'b0};
            p0_resp_valid <= 1'b0;
            p1_resp_valid <= 1'b0;
            p0_rdata      <= 64'd0;
            p1_rdata      <= 64'd0;
            p0_err        <= 1'b0;
            p1_err        <= 1'b0;
        end else begin
            state         <= state_nx;
            p0_resp_valid <= issuing && !cmd.id;
            p1_resp_valid <= issuing && cmd.id;
            if (grant) begin
                cmd <= '{we: s_we, addr: s_addr, wdata: s_wdata, size: s_size, id: sel, legal: legal};
                rr  <= ~sel;
            end
            if (issuing && !cmd.id) begin
                p0_rdata <= rd_cap;
                p0_err   <= ~cmd.legal;
            end
            if (issuing && cmd.id) begin
                p1_rdata <= rd_cap;
                p1_err   <= ~cmd.legal;
            end
        end
    end
endmodule
